// File: rtl/instr_queue.sv
// instr_queue: DEPTH-entry FIFO of fetched LC-3b instruction words that
// replaces the single IR and presents decoded fields of the head entry.
//
// Parameters:
//   DEPTH  number of entries (power of two, >= 2)
//   WIDTH  instruction word width (decode positions assume 16 bits)
//
// Ports:
//   clk, reset             clock and synchronous active-high reset
//   flush                  discard all entries on redirect
//   in_valid/in_ready      fetch side handshake, in_data is the word
//   out_valid/out_ready    control side handshake, out_word is the head
//   count                  current occupancy
//   opcode..d_bit          decoded fields of out_word (combinational)
//
// Optional build macro INSTR_QUEUE_BYPASS_EN: when the queue is empty an
// offered word is presented on the output in the same cycle, and is not
// stored if it is consumed in that cycle.
module instr_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_word,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [3:0]                 opcode,
    output logic [2:0]                 dest,
    output logic [2:0]                 src1,
    output logic [2:0]                 src2,
    output logic [5:0]                 offset6,
    output logic [8:0]                 offset9,
    output logic [10:0]                offset11,
    output logic [4:0]                 imm5,
    output logic                       imm5_enable,
    output logic                       offset11_enable,
    output logic [7:0]                 trapvect8,
    output logic                       a_bit,
    output logic                       d_bit
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;

    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             store;
    logic             bypass;
    logic [WIDTH-1:0] head;

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));

    assign in_ready = !full;
    assign push     = in_valid && in_ready;

    // pop only ever removes a stored entry
    assign pop = !empty && out_ready;

`ifdef INSTR_QUEUE_BYPASS_EN
    assign bypass = empty && in_valid;
`else
    assign bypass = 1'b0;
`endif

    // a bypassed word consumed in the same cycle never enters storage
    assign store = push && !(bypass && out_ready);

    assign out_valid = !empty || bypass;

    always_comb begin
        head = '0;
        if (bypass) begin
            head = in_data;
        end else if (!empty) begin
            head = mem[rd_ptr];
        end
    end

    assign out_word = head;
    assign count    = cnt;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({store, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // storage is deliberately left unreset; empty slots are never observed
    always_ff @(posedge clk) begin
        if (!reset && !flush && store) begin
            mem[wr_ptr] <= in_data;
        end
    end

    assign opcode = head[15:12];
    assign dest   = (opcode == OP_JSR || opcode == OP_TRAP) ?
                    3'b111 : head[11:9];
    assign src1            = head[8:6];
    assign src2            = head[2:0];
    assign offset6         = head[5:0];
    assign offset9         = head[8:0];
    assign offset11        = head[10:0];
    assign imm5            = head[4:0];
    assign imm5_enable     = head[5];
    assign offset11_enable = head[11];
    assign trapvect8       = head[7:0];
    assign a_bit           = head[4];
    assign d_bit           = head[5];

endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: directed self-checking bench for instr_queue.
// Drives handshake sequences and checks occupancy, ordering and decode.
module tb_instr_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_word;
    logic [2:0]  count;
    logic [3:0]  opcode;
    logic [2:0]  dest;
    logic [2:0]  src1;
    logic [2:0]  src2;
    logic [5:0]  offset6;
    logic [8:0]  offset9;
    logic [10:0] offset11;
    logic [4:0]  imm5;
    logic        imm5_enable;
    logic        offset11_enable;
    logic [7:0]  trapvect8;
    logic        a_bit;
    logic        d_bit;

    int n_vec = 0;
    int n_err = 0;

    instr_queue #(.DEPTH(4), .WIDTH(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_word        (out_word),
        .count           (count),
        .opcode          (opcode),
        .dest            (dest),
        .src1            (src1),
        .src2            (src2),
        .offset6         (offset6),
        .offset9         (offset9),
        .offset11        (offset11),
        .imm5            (imm5),
        .imm5_enable     (imm5_enable),
        .offset11_enable (offset11_enable),
        .trapvect8       (trapvect8),
        .a_bit           (a_bit),
        .d_bit           (d_bit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pop1();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_ovalid", 32'(out_valid), 0);
        chk("rst_iready", 32'(in_ready), 1);
        chk("rst_word", 32'(out_word), 0);
        chk("rst_opcode", 32'(opcode), 0);
        chk("rst_dest", 32'(dest), 0);

        // empty pop is a no-op
        pop1();
        chk("empty_pop_cnt", 32'(count), 0);

        // ADD R1,R2,R3
        push1(16'h1283);
        chk("add_ovalid", 32'(out_valid), 1);
        chk("add_opcode", 32'(opcode), 4'h1);
        chk("add_dest", 32'(dest), 1);
        chk("add_src1", 32'(src1), 2);
        chk("add_src2", 32'(src2), 3);
        chk("add_imm_en", 32'(imm5_enable), 0);
        chk("add_count", 32'(count), 1);
        pop1();
        chk("add_pop_cnt", 32'(count), 0);

        // JSR then TRAP
        push1(16'h4801);
        push1(16'hF025);
        chk("jt_count", 32'(count), 2);
        chk("jsr_opcode", 32'(opcode), 4'h4);
        chk("jsr_dest", 32'(dest), 7);
        chk("jsr_o11en", 32'(offset11_enable), 1);
        chk("jsr_o11", 32'(offset11), 11'h001);
        pop1();
        chk("trap_opcode", 32'(opcode), 4'hF);
        chk("trap_dest", 32'(dest), 7);
        chk("trap_vect", 32'(trapvect8), 8'h25);
        pop1();
        chk("jt_empty", 32'(count), 0);

        // fill to full, extra word held by source
        push1(16'h1001);
        push1(16'h1002);
        push1(16'h1003);
        in_valid = 1'b1;
        in_data  = 16'h1004;
        step();
        in_data = 16'h1005;
        #1;
        chk("full_count", 32'(count), 4);
        chk("full_iready", 32'(in_ready), 0);
        step();
        chk("full_hold_cnt", 32'(count), 4);
        chk("full_head", 32'(out_word), 16'h1001);
        // full with pop: 0x1005 still refused this edge
        out_ready = 1'b1;
        step();
        chk("drain1_cnt", 32'(count), 3);
        chk("drain1_head", 32'(out_word), 16'h1002);
        // now 0x1005 is accepted while 0x1002 leaves
        step();
        in_valid = 1'b0;
        chk("drain2_cnt", 32'(count), 3);
        chk("drain2_head", 32'(out_word), 16'h1003);
        step();
        chk("drain3_head", 32'(out_word), 16'h1004);
        step();
        chk("drain4_head", 32'(out_word), 16'h1005);
        chk("drain4_cnt", 32'(count), 1);
        step();
        out_ready = 1'b0;
        chk("drain_empty", 32'(count), 0);
        chk("drain_ovalid", 32'(out_valid), 0);

        // simultaneous push/pop at count 2, wrapping pointers
        push1(16'h2000);
        push1(16'h2001);
        for (int i = 0; i < 8; i++) begin
            in_valid  = 1'b1;
            in_data   = 16'h2002 + 16'(i);
            out_ready = 1'b1;
            #1;
            chk("pp_head", 32'(out_word), 32'h2000 + i);
            step();
            chk("pp_count", 32'(count), 2);
        end
        in_valid = 1'b0;
        #1;
        chk("pp_tail0", 32'(out_word), 16'h2008);
        step();
        chk("pp_tail1", 32'(out_word), 16'h2009);
        step();
        out_ready = 1'b0;
        chk("pp_empty", 32'(count), 0);

        // flush with a push offered
        push1(16'h3000);
        push1(16'h3001);
        push1(16'h3002);
        chk("pre_fl_cnt", 32'(count), 3);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h3FFF;
        out_ready = 1'b1;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("fl_count", 32'(count), 0);
        chk("fl_ovalid", 32'(out_valid), 0);
        chk("fl_iready", 32'(in_ready), 1);
        chk("fl_word", 32'(out_word), 0);
        push1(16'h3100);
        chk("post_fl_head", 32'(out_word), 16'h3100);
        chk("post_fl_cnt", 32'(count), 1);

        // reset mid-stream
        push1(16'h3101);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h3EEE;
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("mr_count", 32'(count), 0);
        chk("mr_ovalid", 32'(out_valid), 0);
        chk("mr_iready", 32'(in_ready), 1);
        push1(16'h3200);
        chk("post_mr_head", 32'(out_word), 16'h3200);
        pop1();
        chk("post_mr_cnt", 32'(count), 0);

`ifdef INSTR_QUEUE_BYPASS_EN
        in_valid  = 1'b1;
        in_data   = 16'h6A42;
        out_ready = 1'b1;
        #1;
        chk("byp_ovalid", 32'(out_valid), 1);
        chk("byp_word", 32'(out_word), 16'h6A42);
        chk("byp_opcode", 32'(opcode), 6);
        chk("byp_dest", 32'(dest), 5);
        chk("byp_src1", 32'(src1), 1);
        chk("byp_off6", 32'(offset6), 6'h02);
        step();
        chk("byp_count", 32'(count), 0);
        out_ready = 1'b0;
        in_data   = 16'h1234;
        #1;
        chk("bys_ovalid", 32'(out_valid), 1);
        step();
        in_valid = 1'b0;
        #1;
        chk("bys_count", 32'(count), 1);
        chk("bys_head", 32'(out_word), 16'h1234);
        pop1();
        chk("bys_empty", 32'(count), 0);
`else
        in_valid  = 1'b1;
        in_data   = 16'h6A42;
        out_ready = 1'b1;
        #1;
        chk("nb_ovalid", 32'(out_valid), 0);
        chk("nb_word", 32'(out_word), 0);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("nb_count", 32'(count), 1);
        chk("nb_opcode", 32'(opcode), 6);
        chk("nb_dest", 32'(dest), 5);
        chk("nb_src1", 32'(src1), 1);
        chk("nb_off6", 32'(offset6), 6'h02);
        pop1();
        chk("nb_empty", 32'(count), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
